// File: rtl/axis_deser_pkg.sv
// Shared types and helpers for the AXI4-Stream packet deserializer.
package axis_deser_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DRAIN   = 2'd2
    } deser_state_t;

    // Number of stream beats that make up one packet.
    function automatic int beats_f(input int package_width, input int tdata_width);
        return package_width / tdata_width;
    endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// Beat index within a packet: synchronous clear, saturating increment, at_last flag.
module axis_beat_counter #(
    parameter int NUM = 50,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         at_last
);

    logic [W-1:0] cnt_reg;

    assign cnt     = cnt_reg;
    assign at_last = (cnt_reg == W'(NUM - 1));

    // Index register; saturates at NUM-1 so it never leaves the slot range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && !at_last) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/axis_pkt_deserializer.sv
// AXI4-Stream sink that assembles NUM beats into one wide packet (beat k at
// bits [W*k +: W]) with TLAST length checking and a valid/ready packet port.
// Optional byte masking by TSTRB is enabled with AXIS_DESER_TSTRB_EN.
module axis_pkt_deserializer
    import axis_deser_pkg::*;
#(
    parameter int PACKAGE_WIDTH        = 1600,
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    output logic [PACKAGE_WIDTH-1:0]          pkt_data_o,
    output logic                              pkt_valid_o,
    input  logic                              pkt_ready_i,
    output logic                              pkt_err_o,
    output logic [CNT_WIDTH-1:0]              pkt_cnt_o
);

    localparam int DW  = C_S_AXIS_TDATA_WIDTH;
    localparam int NUM = beats_f(PACKAGE_WIDTH, C_S_AXIS_TDATA_WIDTH);
    localparam int BW  = (NUM > 1) ? $clog2(NUM) : 1;

    deser_state_t             state_reg, state_next;
    logic                     err_reg, err_next;
    logic [CNT_WIDTH-1:0]     pkt_cnt_reg;
    logic [PACKAGE_WIDTH-1:0] pkt_data_reg, pkt_data_next;
    logic [BW-1:0]            beat_cnt;
    logic                     at_last;
    logic                     cnt_clr, cnt_inc, wr_en, handoff;
    logic                     beat_acc;
    logic [DW-1:0]            beat_data;

    assign S_AXIS_TREADY = (state_reg != HOLD);
    assign beat_acc      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign pkt_valid_o   = (state_reg == HOLD);
    assign pkt_err_o     = err_reg;
    assign pkt_cnt_o     = pkt_cnt_reg;
    assign pkt_data_o    = pkt_data_reg;

`ifdef AXIS_DESER_TSTRB_EN
    // Bytes without a strobe are stored as zero.
    for (genvar gi = 0; gi < DW / 8; gi++) begin : g_strb
        assign beat_data[8*gi +: 8] = S_AXIS_TSTRB[gi] ? S_AXIS_TDATA[8*gi +: 8] : 8'h00;
    end
`else
    logic unused_strb;
    assign unused_strb = ^S_AXIS_TSTRB;
    assign beat_data   = S_AXIS_TDATA;
`endif

    axis_beat_counter #(.NUM(NUM), .W(BW)) u_beat_counter (
        .clk     (S_AXIS_ACLK),
        .rst_n   (S_AXIS_ARESETN),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .cnt     (beat_cnt),
        .at_last (at_last)
    );

    // Per-slot next value: the addressed slot takes the beat, and the first
    // beat of a packet wipes every other slot so short packets read zero.
    for (genvar gi = 0; gi < NUM; gi++) begin : g_slot
        assign pkt_data_next[DW*gi +: DW] =
            !wr_en                  ? pkt_data_reg[DW*gi +: DW] :
            (beat_cnt == BW'(gi))   ? beat_data :
            (beat_cnt == '0)        ? '0 :
                                      pkt_data_reg[DW*gi +: DW];
    end

    // Next-state logic: length check against TLAST and handoff control.
    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        wr_en      = 1'b0;
        handoff    = 1'b0;
        case (state_reg)
            COLLECT: begin
                if (beat_acc) begin
                    wr_en = 1'b1;
                    if (S_AXIS_TLAST) begin
                        state_next = HOLD;
                        err_next   = !at_last;
                    end else if (at_last) begin
                        state_next = DRAIN;
                        err_next   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (beat_acc && S_AXIS_TLAST) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (pkt_ready_i) begin
                    state_next = COLLECT;
                    err_next   = 1'b0;
                    cnt_clr    = 1'b1;
                    handoff    = 1'b1;
                end
            end
            default: begin
                state_next = COLLECT;
                err_next   = 1'b0;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    // State, error flag, packet register and handoff counter.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_reg    <= COLLECT;
            err_reg      <= 1'b0;
            pkt_data_reg <= '0;
            pkt_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            err_reg      <= err_next;
            pkt_data_reg <= pkt_data_next;
            if (handoff) begin
                pkt_cnt_reg <= pkt_cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_deserializer.sv
// Directed testbench for axis_pkt_deserializer (also covers AXIS_DESER_TSTRB_EN).
module tb_axis_pkt_deserializer;

    localparam int PW  = 1600;
    localparam int DW  = 32;
    localparam int NUM = 50;

    logic            clk;
    logic            rst_n;
    logic            tvalid;
    logic            tready;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic            tlast;
    logic [PW-1:0]   pkt_data;
    logic            pkt_valid;
    logic            pkt_ready;
    logic            pkt_err;
    logic [15:0]     pkt_cnt;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_slot [NUM];
    logic [15:0] exp_cnt;

    axis_pkt_deserializer #(
        .PACKAGE_WIDTH        (PW),
        .C_S_AXIS_TDATA_WIDTH (DW),
        .CNT_WIDTH            (16)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .S_AXIS_TVALID  (tvalid),
        .S_AXIS_TREADY  (tready),
        .S_AXIS_TDATA   (tdata),
        .S_AXIS_TSTRB   (tstrb),
        .S_AXIS_TLAST   (tlast),
        .pkt_data_o     (pkt_data),
        .pkt_valid_o    (pkt_valid),
        .pkt_ready_i    (pkt_ready),
        .pkt_err_o      (pkt_err),
        .pkt_cnt_o      (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one beat from a falling edge and hold it until it is accepted.
    task automatic send_beat(input logic [31:0] d, input logic l, input logic [3:0] s);
        int budget;
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        tstrb  = s;
        budget = 200;
        while (!tready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check_eq("tready_timeout", 32'(tready), 32'd1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // n beats of base+k, TLAST on the final one; builds the expected slots.
    task automatic send_pkt(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) send_beat(base + 32'(k), (k == n - 1), 4'hF);
        for (int k = 0; k < NUM; k++) exp_slot[k] = (k < n) ? base + 32'(k) : 32'd0;
    endtask

    // Checks the held packet, then the handoff on the next edge (pkt_ready=1).
    task automatic check_pkt(input string tag, input logic exp_err);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(pkt_valid), 32'd1);
        check_eq({tag, "_err"}, 32'(pkt_err), 32'(exp_err));
        check_eq({tag, "_tready_hold"}, 32'(tready), 32'd0);
        for (int k = 0; k < NUM; k++)
            check_eq($sformatf("%s_slot%0d", tag, k), pkt_data[32*k +: 32], exp_slot[k]);
        @(posedge clk);
        #1;
        exp_cnt++;
        check_eq({tag, "_valid_after"}, 32'(pkt_valid), 32'd0);
        check_eq({tag, "_cnt"}, 32'(pkt_cnt), 32'(exp_cnt));
        check_eq({tag, "_tready_after"}, 32'(tready), 32'd1);
        $display("packet %s done, cnt=%0d", tag, pkt_cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_cnt   = 16'd0;
        rst_n     = 1'b0;
        tvalid    = 1'b0;
        tdata     = '0;
        tstrb     = '0;
        tlast     = 1'b0;
        pkt_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", 32'(pkt_valid), 32'd0);
        check_eq("rst_err", 32'(pkt_err), 32'd0);
        check_eq("rst_cnt", 32'(pkt_cnt), 32'd0);
        check_eq("rst_data0", pkt_data[31:0], 32'd0);
        check_eq("rst_tready", 32'(tready), 32'd1);
        rst_n = 1'b1;

        // 1: nominal 50-beat packet
        pkt_ready = 1'b1;
        send_pkt(50, 32'd1);
        check_pkt("t1", 1'b0);

        // 2: backpressure with the next packet's first beat pending
        pkt_ready = 1'b0;
        send_pkt(50, 32'd101);
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = 32'd200;
        tlast  = 1'b0;
        tstrb  = 4'hF;
        for (int c = 0; c < 20; c++) begin
            check_eq($sformatf("t2_tready_c%0d", c), 32'(tready), 32'd0);
            check_eq($sformatf("t2_valid_c%0d", c), 32'(pkt_valid), 32'd1);
            check_eq($sformatf("t2_slot0_c%0d", c), pkt_data[31:0], 32'd101);
            check_eq($sformatf("t2_slot49_c%0d", c), pkt_data[1599:1568], 32'd150);
            @(negedge clk);
        end
        pkt_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt++;
        check_eq("t2_cnt", 32'(pkt_cnt), 32'(exp_cnt));
        check_eq("t2_valid_after", 32'(pkt_valid), 32'd0);
        check_eq("t2_tready_after", 32'(tready), 32'd1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        for (int k = 1; k < NUM; k++) send_beat(32'd200 + 32'(k), (k == NUM - 1), 4'hF);
        for (int k = 0; k < NUM; k++) exp_slot[k] = 32'd200 + 32'(k);
        check_pkt("t2pend", 1'b0);

        // 3: short packet of 10 beats
        send_pkt(10, 32'd300);
        check_pkt("t3", 1'b1);

        // 4: long packet of 60 beats, then a clean one
        send_pkt(60, 32'd400);
        check_pkt("t4", 1'b1);
        send_pkt(50, 32'd500);
        check_pkt("t4clean", 1'b0);

        // single-beat packet
        send_pkt(1, 32'hCAFE0000);
        check_pkt("single", 1'b1);

        // 5: reset in the middle of a packet
        for (int k = 0; k < 25; k++) send_beat(32'd600 + 32'(k), 1'b0, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t5_valid", 32'(pkt_valid), 32'd0);
        check_eq("t5_err", 32'(pkt_err), 32'd0);
        check_eq("t5_cnt", 32'(pkt_cnt), 32'd0);
        check_eq("t5_slot0", pkt_data[31:0], 32'd0);
        check_eq("t5_slot24", pkt_data[799:768], 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 16'd0;
        send_pkt(50, 32'd700);
        check_pkt("t5", 1'b0);

        // 6: partial strobes on beat 0
        send_beat(32'hAABBCCDD, 1'b0, 4'b0101);
        for (int k = 1; k < NUM; k++) send_beat(32'd800 + 32'(k), (k == NUM - 1), 4'hF);
        for (int k = 1; k < NUM; k++) exp_slot[k] = 32'd800 + 32'(k);
`ifdef AXIS_DESER_TSTRB_EN
        exp_slot[0] = 32'h00BB00DD;
`else
        exp_slot[0] = 32'hAABBCCDD;
`endif
        check_pkt("t6", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
